// File: rtl/spi_slave_regs_if.sv
// SPI bus bundle between the housekeeping SPI master and the register-model
// responder. Signal names follow the responder's view of the link.
interface spi_slave_regs_if;
    logic spi_cs_i;    // chip select, active low
    logic spi_clk_i;   // SPI clock, idle high
    logic spi_mosi_i;  // serial data towards the responder
    logic spi_miso_o;  // serial data from the responder
    logic spi_miso_t;  // MISO tristate control, 1 = high-Z

    modport slave (
        input  spi_cs_i,
        input  spi_clk_i,
        input  spi_mosi_i,
        output spi_miso_o,
        output spi_miso_t
    );

    modport master (
        output spi_cs_i,
        output spi_clk_i,
        output spi_mosi_i,
        input  spi_miso_o,
        input  spi_miso_t
    );
endinterface

// File: rtl/spi_slave_regs.sv
// SPI responder with a small register file, the far end of the housekeeping
// ADC-configuration link. Frames are an ADR_W-bit address (MSB = read flag)
// followed by DAT_W data bits, MSB first, CS low, SCLK idle high, data
// sampled on the SCLK rising edge. All SPI inputs are oversampled by clk_i.
module spi_slave_regs #(
    parameter int                    ADR_W    = 8,
    parameter int                    DAT_W    = 8,
    parameter int                    NREG     = 8,
    parameter logic [NREG*DAT_W-1:0] REG_INIT = {NREG*DAT_W{1'b0}}
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    spi_slave_regs_if.slave        spi,
    output logic [NREG*DAT_W-1:0]  reg_o,
    output logic                   wr_stb_o,
    output logic [ADR_W-2:0]       wr_adr_o,
    output logic [DAT_W-1:0]       wr_dat_o,
    output logic                   frame_err_o,
    output logic [15:0]            frame_cnt_o,
    output logic [7:0]             err_cnt_o
);

    localparam int         FRM_W    = ADR_W + DAT_W;
    localparam int         IW       = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int         SH_W     = (DAT_W > ADR_W - 1) ? DAT_W : ADR_W - 1;
    localparam logic [4:0] FRM_CNT  = 5'(FRM_W);
    localparam logic [4:0] ADR_LAST = 5'(ADR_W - 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t state, state_nxt;

    // synchroniser stages (p0, p1) and edge stage (p2)
    logic cs_p0, cs_p1, cs_p2;
    logic sclk_p0, sclk_p1, sclk_p2;
    logic mosi_p0, mosi_p1, mosi_p2;
    logic cs_rise_p2, cs_fall_p2, sclk_rise_p2, sclk_fall_p2;

    // frame datapath
    logic [SH_W-1:0]  shift_q;
    logic [4:0]       bit_cnt;
    logic             rw_q;
    logic [ADR_W-2:0] idx_q;
    logic [DAT_W-1:0] tx_q;
    logic             miso_q;
    logic             miso_t_q;
    logic [DAT_W-1:0] regs [NREG];

    // address as it stands once the last address bit is shifted in
    logic [ADR_W-1:0] adr_nxt;
    logic [ADR_W-2:0] adr_idx;
    logic             idx_ok;

    // FSM decisions consumed by the datapath
    logic start_frm, shift_in, adr_done, drive_miso, end_frame;
    logic commit_wr, commit_rd, frame_bad;

    assign adr_nxt = {shift_q[ADR_W-2:0], mosi_p2};
    assign adr_idx = adr_nxt[ADR_W-2:0];
    assign idx_ok  = (32'(adr_idx) < 32'(NREG));

    assign spi.spi_miso_o = miso_q;
    assign spi.spi_miso_t = miso_t_q;

    // Bring CS/SCLK/MOSI into clk_i and register their edges. CS resets low
    // so that a frame already running at reset release is never mistaken
    // for idle; SCLK resets to its idle-high level to avoid a false edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cs_p0        <= 1'b0;
            cs_p1        <= 1'b0;
            cs_p2        <= 1'b0;
            sclk_p0      <= 1'b1;
            sclk_p1      <= 1'b1;
            sclk_p2      <= 1'b1;
            mosi_p0      <= 1'b0;
            mosi_p1      <= 1'b0;
            mosi_p2      <= 1'b0;
            cs_rise_p2   <= 1'b0;
            cs_fall_p2   <= 1'b0;
            sclk_rise_p2 <= 1'b0;
            sclk_fall_p2 <= 1'b0;
        end else begin
            cs_p0        <= spi.spi_cs_i;
            cs_p1        <= cs_p0;
            cs_p2        <= cs_p1;
            sclk_p0      <= spi.spi_clk_i;
            sclk_p1      <= sclk_p0;
            sclk_p2      <= sclk_p1;
            mosi_p0      <= spi.spi_mosi_i;
            mosi_p1      <= mosi_p0;
            mosi_p2      <= mosi_p1;
            cs_rise_p2   <= cs_p1 & ~cs_p2;
            cs_fall_p2   <= ~cs_p1 & cs_p2;
            sclk_rise_p2 <= sclk_p1 & ~sclk_p2;
            sclk_fall_p2 <= ~sclk_p1 & sclk_p2;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle frame decisions; CS rising ends every frame
    always_comb begin
        state_nxt  = state;
        start_frm  = 1'b0;
        shift_in   = 1'b0;
        adr_done   = 1'b0;
        drive_miso = 1'b0;
        end_frame  = 1'b0;
        commit_wr  = 1'b0;
        commit_rd  = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (cs_p2) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall_p2) begin
                    start_frm = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR, DATA: begin
                if (cs_rise_p2) begin
                    end_frame = 1'b1;
                    state_nxt = IDLE;
                    if (bit_cnt != 5'd0) begin
                        if (bit_cnt != FRM_CNT) begin
                            frame_bad = 1'b1;
                        end else if (rw_q) begin
                            commit_rd = 1'b1;
                        end else if (32'(idx_q) < 32'(NREG)) begin
                            commit_wr = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end
                end else begin
                    if (sclk_rise_p2) begin
                        shift_in = 1'b1;
                        if (state == ADDR && bit_cnt == ADR_LAST) begin
                            adr_done  = 1'b1;
                            state_nxt = DATA;
                        end
                    end
                    if (state == DATA && sclk_fall_p2 && rw_q) begin
                        drive_miso = 1'b1;
                    end
                end
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    // Shift/count bits, serve reads on MISO, commit writes and keep counters
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shift_q     <= '0;
            bit_cnt     <= '0;
            rw_q        <= 1'b0;
            idx_q       <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            miso_t_q    <= 1'b1;
            wr_stb_o    <= 1'b0;
            wr_adr_o    <= '0;
            wr_dat_o    <= '0;
            frame_err_o <= 1'b0;
            frame_cnt_o <= '0;
            err_cnt_o   <= '0;
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= REG_INIT[k*DAT_W +: DAT_W];
            end
        end else begin
            wr_stb_o    <= 1'b0;
            frame_err_o <= 1'b0;
            if (start_frm) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end
            if (shift_in) begin
                shift_q <= {shift_q[SH_W-2:0], mosi_p2};
                if (bit_cnt != 5'h1F) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (adr_done) begin
                rw_q  <= adr_nxt[ADR_W-1];
                idx_q <= adr_idx;
                tx_q  <= (adr_nxt[ADR_W-1] && idx_ok) ? regs[adr_idx[IW-1:0]] : '0;
            end
            if (drive_miso) begin
                miso_q   <= tx_q[DAT_W-1];
                tx_q     <= {tx_q[DAT_W-2:0], 1'b0};
                miso_t_q <= 1'b0;
            end
            if (end_frame) begin
                miso_t_q <= 1'b1;
            end
            if (commit_wr) begin
                regs[idx_q[IW-1:0]] <= shift_q[DAT_W-1:0];
                wr_stb_o            <= 1'b1;
                wr_adr_o            <= idx_q;
                wr_dat_o            <= shift_q[DAT_W-1:0];
                frame_cnt_o         <= frame_cnt_o + 16'd1;
            end
            if (commit_rd) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
            if (frame_bad) begin
                frame_err_o <= 1'b1;
                if (err_cnt_o != 8'hFF) begin
                    err_cnt_o <= err_cnt_o + 8'd1;
                end
            end
        end
    end

    // Flatten the register file onto the output bus
    always_comb begin
        reg_o = '0;
        for (int k = 0; k < NREG; k++) begin
            reg_o[k*DAT_W +: DAT_W] = regs[k];
        end
    end

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
SPI responder that forms the far end of the housekeeping ADC-configuration SPI link. It accepts the frames `spi_master` generates: CS active low, SCLK idle high, MOSI changed on the falling edge and sampled on the rising edge, MSB first, 8-bit address followed by 8-bit data. Writes go into a small register file; reads drive MISO. Used as an ADC register model in simulation and as the SPI target in loopback/bring-up builds.

Parameters:
ADR_W, 8, address field width; MSB is the R/W bit (1 = read).
DAT_W, 8, data field width.
NREG, 8, number of implemented registers (indices 0..NREG-1).
REG_INIT, {NREG*DAT_W{1'b0}}, reset value of the register file.

Ports:
clk_i  in  1  system clock (125 MHz).
rstn_i  in  1  reset, asynchronous, active low.
spi_cs_i  in  1  chip select, active low, asynchronous to clk_i.
spi_clk_i  in  1  SPI clock, idle high, asynchronous.
spi_mosi_i  in  1  serial data in.
spi_miso_o  out  1  serial data out.
spi_miso_t  out  1  MISO tristate, 1 = high-Z.
reg_o  out  NREG*DAT_W  register file, register k at [k*DAT_W +: DAT_W].
wr_stb_o  out  1  one-cycle pulse on a committed write.
wr_adr_o  out  ADR_W-1  index of the last committed write.
wr_dat_o  out  DAT_W  data of the last committed write.
frame_err_o  out  1  one-cycle pulse on a rejected frame.
frame_cnt_o  out  16  count of good frames, wraps.
err_cnt_o  out  8  count of rejected frames, saturates at 255.

Behaviour:
- Synchronisation: cs, clk and mosi each pass through a 2-FF synchroniser. Edge detection uses one further stage.
- SCLK constraint: each SCLK half-period must be at least 4 clk_i cycles. At presc 10 (12.5 MHz) this is met.
- Reset values: reg_o = REG_INIT; spi_miso_t = 1; spi_miso_o = 0; wr_stb_o, frame_err_o = 0; wr_adr_o, wr_dat_o = 0; both counters = 0; state = WAIT_IDLE.
- WAIT_IDLE: go to IDLE once synced CS is high. A frame already in progress when reset releases is therefore ignored.
- IDLE: on synced CS falling edge, clear the shift register and bit counter (5 bits, saturating at 31), then go to ADDR.
- ADDR: each synced SCLK rising edge shifts in MOSI and increments the bit counter. After ADR_W bits:
  - latch the address and rw = adr[ADR_W-1];
  - if rw = 1, load the tx shift register with reg[adr[ADR_W-2:0]], or 0 if the index is ≥ NREG;
  - go to DATA.
- DATA, rising edges: keep shifting and counting.
- DATA, falling edges, read frames only:
  - drive spi_miso_o = tx MSB, then shift tx left;
  - spi_miso_t = 0 from the first falling edge after the address until CS rises;
  - the master therefore samples the data MSB on SCLK rising edge ADR_W+1.
- CS rising edge, any state except IDLE/WAIT_IDLE, evaluated in one cycle:
  - bit count = 0: silent return to IDLE, no error.
  - bit count = ADR_W+DAT_W, write, index < NREG:
    - update the register;
    - wr_stb_o = 1 for one cycle, with wr_adr_o and wr_dat_o updated;
    - frame_cnt_o += 1.
  - bit count = ADR_W+DAT_W, read: frame_cnt_o += 1, no strobe.
  - write with index ≥ NREG: no update, frame_err_o pulse, err_cnt_o += 1.
  - bit count ≠ ADR_W+DAT_W (short or long frame): no update, frame_err_o pulse, err_cnt_o += 1.
  - In all cases: spi_miso_t = 1, return to IDLE.
- Latency: wr_stb_o and reg_o change exactly 4 clk_i cycles after raw CS rises (2 sync + 1 edge + 1 register).
- A CS falling edge in the same evaluation cycle as frame end cannot occur, because CS must stay high for at least 1 SCLK half-period. Consecutive frames need no other gap.
- Reset asserted mid-frame: everything returns immediately to reset values, the frame is discarded, and the block waits in WAIT_IDLE.

Test Plan:
1. Write frame adr 0x03, dat 0x02 -> reg_o[31:24] = 0x02; single wr_stb_o pulse with wr_adr_o = 3, wr_dat_o = 0x02, 4 clk after CS rises; frame_cnt_o = 1.
2. After test 1, read frame adr 0x83 -> MISO carries 0x02 MSB-first on falling edges 8..15; spi_miso_t is low only during the data phase; reg_o unchanged; no wr_stb_o.
3. CS raised after 12 bits of a write to adr 0x01 -> reg 1 unchanged, one frame_err_o pulse, err_cnt_o = 1. A subsequent CS pulse with 0 bits -> no error.
4. Write adr 0x0A, dat 0x55 with NREG = 8 -> no register changes, frame_err_o pulse. Read adr 0x8A -> MISO returns 0x00.
5. Init sequence back to back, 1 SCLK half-period CS-high gap: (0x01,0x00), (0x02,0x01), (0x03,0x02), (0x04,0x00) -> regs 1..4 = 0x00, 0x01, 0x02, 0x00; four wr_stb_o pulses; frame_cnt_o = 4.
6. rstn_i pulsed low at bit 6 of a write with CS held low -> outputs return to reset values; remaining bits ignored, no strobe. After CS high, a write of (0x02,0xAA) -> reg 2 = 0xAA.
